// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - Shared state encoding, widths and saturation helper for the AD9767 driver.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RAMP = 2'd2
  } state_t;

  localparam int DAC_W_DEF = 14;
  localparam int MID_CODE  = 1 << (DAC_W_DEF - 1);
  localparam int SUM_W     = 18;

  // Clamp a signed trimmed sum into the 0..max_v code range.
  function automatic logic signed [SUM_W-1:0] saturate(
    input logic signed [SUM_W-1:0] s,
    input logic signed [SUM_W-1:0] max_v
  );
    if (s < 0) return '0;
    else if (s > max_v) return max_v;
    else return s;
  endfunction

endpackage

// File: rtl/dac_slew_limiter.sv
// rtl/dac_slew_limiter.sv - Per-channel output register that walks toward its target code.
// DAC_SLEW_LIMIT_EN bounds each step to SLEW_STEP; otherwise the output follows the target every edge.
module dac_slew_limiter #(
  parameter int DAC_WIDTH = 14,
  parameter int SLEW_STEP = 64
) (
  input  logic                 da_clk,
  input  logic                 rst,
  input  logic [DAC_WIDTH-1:0] target,
  input  logic                 force_mid,
  output logic [DAC_WIDTH-1:0] out,
  output logic                 changed
);

  localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};
  localparam int FULL = 1 << DAC_WIDTH;
`ifdef DAC_SLEW_LIMIT_EN
  localparam int LIMIT = SLEW_STEP;
`else
  // A step of at least full scale never clamps, so out lands on target each edge.
  localparam int LIMIT = (SLEW_STEP > FULL) ? SLEW_STEP : FULL;
`endif

  int                   diff;
  logic [DAC_WIDTH-1:0] out_nxt;
  logic [DAC_WIDTH-1:0] out_d;

  always_comb begin
    diff    = int'(target) - int'(out);
    out_nxt = target;
    if (diff > LIMIT) out_nxt = out + DAC_WIDTH'(LIMIT);
    else if (diff < -LIMIT) out_nxt = out - DAC_WIDTH'(LIMIT);
    out_d = force_mid ? MID : out_nxt;
  end

  always_ff @(posedge da_clk) begin
    if (rst) begin
      out     <= MID;
      changed <= 1'b0;
    end else begin
      out     <= out_d;
      changed <= (out_d != out);
    end
  end

endmodule

// File: rtl/ad9767.sv
// rtl/ad9767.sv - Dual-channel AD9767 driver: trim, saturate, offset-binary coding, ramp-to-mid shutdown.
// DAC_SLEW_LIMIT_EN compiles in the slew limiter; otherwise RAMP snaps outputs to midscale in one cycle.
module ad9767
  import dac_pkg::*;
#(
  parameter int                DAC_WIDTH  = DAC_W_DEF,
  parameter int                SLEW_STEP  = 64,
  parameter logic signed [15:0] OFFSET_CH1 = 16'sd0,
  parameter logic signed [15:0] OFFSET_CH2 = 16'sd0
) (
  input  logic                 da_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [15:0]          volt_ch1,
  input  logic [15:0]          volt_ch2,
  input  logic                 volt_valid,
  output logic                 volt_ready,
  output logic [DAC_WIDTH-1:0] da1_out,
  output logic [DAC_WIDTH-1:0] da2_out,
  output logic                 da_update,
  output logic                 sat,
  output logic                 busy
);

  localparam logic [DAC_WIDTH-1:0]    MID   = {1'b1, {(DAC_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 << DAC_WIDTH) - 1);
  localparam logic signed [SUM_W-1:0] MID_S = SUM_W'(MID);
  localparam logic signed [SUM_W-1:0] OFF1  = {{(SUM_W-16){OFFSET_CH1[15]}}, OFFSET_CH1};
  localparam logic signed [SUM_W-1:0] OFF2  = {{(SUM_W-16){OFFSET_CH2[15]}}, OFFSET_CH2};

  state_t                  state, next_state;
  logic signed [SUM_W-1:0] sum1, sum2, clamp1, clamp2;
  logic                    clip1, clip2, load, force_mid, upd1, upd2;
  logic [DAC_WIDTH-1:0]    target1, target2;

  always_comb begin
    sum1   = $signed({{(SUM_W-16){volt_ch1[15]}}, volt_ch1}) + OFF1 + MID_S;
    sum2   = $signed({{(SUM_W-16){volt_ch2[15]}}, volt_ch2}) + OFF2 + MID_S;
    clamp1 = saturate(sum1, MAX_V);
    clamp2 = saturate(sum2, MAX_V);
    clip1  = (clamp1 != sum1);
    clip2  = (clamp2 != sum2);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = RUN;
      RUN:     if (!enable) next_state = RAMP;
      RAMP:    if (da1_out == MID && da2_out == MID) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A pair offered on the edge that leaves RUN is dropped in favour of the MID target.
  assign load = volt_valid && volt_ready && (state == RUN) && (next_state == RUN);

`ifdef DAC_SLEW_LIMIT_EN
  assign force_mid = (state == IDLE);
`else
  assign force_mid = (next_state != RUN);
`endif

  always_ff @(posedge da_clk) begin
    if (rst) begin
      state      <= IDLE;
      volt_ready <= 1'b0;
      sat        <= 1'b0;
      target1    <= MID;
      target2    <= MID;
    end else begin
      state      <= next_state;
      volt_ready <= (state == RUN);
      sat        <= load && (clip1 || clip2);
      if (next_state != RUN) begin
        target1 <= MID;
        target2 <= MID;
      end else if (load) begin
        target1 <= clamp1[DAC_WIDTH-1:0];
        target2 <= clamp2[DAC_WIDTH-1:0];
      end
    end
  end

  dac_slew_limiter #(.DAC_WIDTH(DAC_WIDTH), .SLEW_STEP(SLEW_STEP)) u_slew_ch1 (
    .da_clk    (da_clk),
    .rst       (rst),
    .target    (target1),
    .force_mid (force_mid),
    .out       (da1_out),
    .changed   (upd1)
  );

  dac_slew_limiter #(.DAC_WIDTH(DAC_WIDTH), .SLEW_STEP(SLEW_STEP)) u_slew_ch2 (
    .da_clk    (da_clk),
    .rst       (rst),
    .target    (target2),
    .force_mid (force_mid),
    .out       (da2_out),
    .changed   (upd2)
  );

  assign da_update = upd1 | upd2;
  assign busy      = (state != IDLE);

endmodule
